// File: rtl/matrix_op_scheduler.sv
// Two-requester scheduler for a matrix calc unit.
// Round-robin grant, single launch pulse, timed wait, held response.
module matrix_op_scheduler #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic [3:0] req_op_0,
    input  logic [3:0] req_op_1,
    input  logic [3:0] req_scalar_0,
    input  logic [3:0] req_scalar_1,
    output logic [1:0] req_ready,
    output logic       calc_start,
    output logic [3:0] calc_op_type,
    output logic [3:0] calc_scalar,
    output logic       calc_sel,
    input  logic       calc_done,
    input  logic       calc_error,
    output logic [1:0] rsp_valid,
    input  logic [1:0] rsp_ready,
    output logic       rsp_error,
    output logic       rsp_timeout,
    output logic       busy,
    output logic [7:0] ops_done,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t     state;
    state_t     state_nx;
    logic       rr_ptr;
    logic [7:0] cnt;
    logic       grant_id;
    logic [3:0] grant_op;
    logic [3:0] grant_scalar;
    logic       op_legal;
    logic       take;
    logic       rsp_hs;
    logic       done_seen;
    logic       timed_out;

    // Arbitration: preferred requester wins a tie, a lone requester always wins.
    always_comb begin
        grant_id = req_valid[1];
        if (req_valid == 2'b11) begin
            grant_id = rr_ptr;
        end
        grant_op     = grant_id ? req_op_1 : req_op_0;
        grant_scalar = grant_id ? req_scalar_1 : req_scalar_0;
        op_legal     = 1'b0;
        case (grant_op)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    end

    // WAIT exit conditions; done is ignored in the first WAIT cycle.
    always_comb begin
        done_seen = (state == WAIT) && (cnt != 8'd0) && calc_done;
        timed_out = (state == WAIT) && !done_seen && (cnt == TMO);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx   = state;
        req_ready  = 2'b00;
        calc_start = 1'b0;
        rsp_valid  = 2'b00;
        take       = 1'b0;
        rsp_hs     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rst && (req_valid != 2'b00)) begin
                    req_ready[grant_id] = 1'b1;
                    take                = 1'b1;
                    state_nx            = op_legal ? LAUNCH : RESP;
                end
            end
            LAUNCH: begin
                calc_start = 1'b1;
                state_nx   = WAIT;
            end
            WAIT: begin
                if (done_seen || timed_out) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                rsp_valid[calc_sel] = 1'b1;
                if (rsp_ready[calc_sel]) begin
                    rsp_hs   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Latched request, wait counter, response status and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= 1'b0;
            cnt          <= 8'd0;
            calc_sel     <= 1'b0;
            calc_op_type <= 4'd0;
            calc_scalar  <= 4'd0;
            rsp_error    <= 1'b0;
            rsp_timeout  <= 1'b0;
            ops_done     <= 8'd0;
            err_cnt      <= 8'd0;
        end else begin
            if (take) begin
                calc_sel     <= grant_id;
                calc_op_type <= grant_op;
                calc_scalar  <= grant_scalar;
                rsp_error    <= !op_legal;
                rsp_timeout  <= 1'b0;
            end
            if (state == LAUNCH) begin
                cnt <= 8'd0;
            end else if (state == WAIT) begin
                cnt <= cnt + 8'd1;
            end
            if (done_seen) begin
                rsp_error   <= calc_error;
                rsp_timeout <= 1'b0;
            end else if (timed_out) begin
                rsp_error   <= 1'b1;
                rsp_timeout <= 1'b1;
            end
            if (rsp_hs) begin
                ops_done <= ops_done + 8'd1;
                rr_ptr   <= ~calc_sel;
                if (rsp_error && (err_cnt != 8'hff)) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_op_scheduler.sv
// Self-checking bench for matrix_op_scheduler.
// Expected responses are queued at grant and popped at rsp_valid.
module tb_matrix_op_scheduler;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [3:0] req_op_0, req_op_1;
    logic [3:0] req_scalar_0, req_scalar_1;
    logic [1:0] req_ready;
    logic       calc_start;
    logic [3:0] calc_op_type, calc_scalar;
    logic       calc_sel;
    logic       calc_done, calc_error;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic       rsp_error, rsp_timeout, busy;
    logic [7:0] ops_done, err_cnt;

    typedef struct packed {
        logic id;
        logic err;
        logic to;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;

    logic       m_rr = 1'b0;
    logic [7:0] m_ops = 8'd0;
    logic [7:0] m_err = 8'd0;

    matrix_op_scheduler #(.TIMEOUT(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_op_0(req_op_0),
        .req_op_1(req_op_1),
        .req_scalar_0(req_scalar_0),
        .req_scalar_1(req_scalar_1),
        .req_ready(req_ready),
        .calc_start(calc_start),
        .calc_op_type(calc_op_type),
        .calc_scalar(calc_scalar),
        .calc_sel(calc_sel),
        .calc_done(calc_done),
        .calc_error(calc_error),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout),
        .busy(busy),
        .ops_done(ops_done),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation; done_at is the cycle offset from accept at
    // which calc_done goes high (-1 = never), stall delays rsp_ready.
    task automatic run_op(input logic [1:0] v, input logic [3:0] o0,
                          input logic [3:0] o1, input logic [3:0] s0,
                          input logic [3:0] s1, input int done_at,
                          input logic cerr, input int stall);
        logic       g;
        logic       legal;
        logic [3:0] gop, gs;
        logic [1:0] rv0;
        logic       re0, rt0;
        exp_t       e, a;
        int         exp_lat, eff, lat;
        bit         got;
        g     = (v == 2'b11) ? m_rr : v[1];
        gop   = g ? o1 : o0;
        gs    = g ? s1 : s0;
        legal = (gop == 4'b0001) || (gop == 4'b0010) ||
                (gop == 4'b0100) || (gop == 4'b1000);
        if (!legal) begin
            exp_lat = 1;
            e = '{id: g, err: 1'b1, to: 1'b0};
        end else begin
            eff = (done_at < 3) ? 3 : done_at;
            if (done_at >= 0 && (eff - 2) <= TMO) begin
                exp_lat = eff + 1;
                e = '{id: g, err: cerr, to: 1'b0};
            end else begin
                exp_lat = TMO + 3;
                e = '{id: g, err: 1'b1, to: 1'b1};
            end
        end
        exp_q.push_back(e);
        req_valid    = v;
        req_op_0     = o0;
        req_op_1     = o1;
        req_scalar_0 = s0;
        req_scalar_1 = s1;
        calc_done    = (done_at == 0);
        calc_error   = cerr;
        rsp_ready    = g ? 2'b01 : 2'b10;
        #1;
        checks++;
        if (req_ready !== (g ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL req_ready got=%b exp=%b", req_ready,
                     (g ? 2'b10 : 2'b01));
        end
        tick();
        req_valid = 2'b00;
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            calc_done = (done_at >= 0) && (k >= done_at);
            #1;
            checks++;
            if (calc_start !== (legal && k == 1)) begin
                failures++;
                $display("FAIL calc_start k=%0d got=%b exp=%b", k,
                         calc_start, (legal && k == 1));
            end
            checks++;
            if (calc_sel !== g || calc_op_type !== gop ||
                calc_scalar !== gs) begin
                failures++;
                $display("FAIL latched k=%0d got=%b/%h/%h exp=%b/%h/%h",
                         k, calc_sel, calc_op_type, calc_scalar, g, gop, gs);
            end
            if (rsp_valid !== 2'b00) begin
                got = 1'b1;
                lat = k;
                break;
            end
            tick();
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL rsp_wait got=none exp=rsp within 30 cycles");
            void'(exp_q.pop_front());
            rst = 1'b1;
            tick();
            rst = 1'b0;
            m_rr  = 1'b0;
            m_ops = 8'd0;
            m_err = 8'd0;
            return;
        end
        a = exp_q.pop_front();
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL latency got=%0d exp=%0d", lat, exp_lat);
        end
        checks++;
        if (rsp_valid !== (a.id ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL rsp_valid got=%b exp=%b", rsp_valid,
                     (a.id ? 2'b10 : 2'b01));
        end
        checks++;
        if (rsp_error !== a.err || rsp_timeout !== a.to) begin
            failures++;
            $display("FAIL rsp_status got=%b%b exp=%b%b", rsp_error,
                     rsp_timeout, a.err, a.to);
        end
        rv0 = rsp_valid;
        re0 = rsp_error;
        rt0 = rsp_timeout;
        for (int i = 0; i < stall; i++) begin
            req_valid = 2'b11;
            calc_done = ~calc_done;
            tick();
            checks++;
            if (rsp_valid !== rv0 || rsp_error !== re0 ||
                rsp_timeout !== rt0 || req_ready !== 2'b00) begin
                failures++;
                $display("FAIL stall i=%0d got=%b/%b%b/%b exp=%b/%b%b/00",
                         i, rsp_valid, rsp_error, rsp_timeout, req_ready,
                         rv0, re0, rt0);
            end
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        calc_done = 1'b0;
        tick();
        m_ops = m_ops + 8'd1;
        if (a.err && m_err != 8'hff) m_err = m_err + 8'd1;
        m_rr = ~g;
        checks++;
        if (ops_done !== m_ops || err_cnt !== m_err || busy !== 1'b0) begin
            failures++;
            $display("FAIL counters got=%0d/%0d/%b exp=%0d/%0d/0",
                     ops_done, err_cnt, busy, m_ops, m_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        tick();
        tick();
        checks++;
        if (req_ready !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=00", req_ready);
        end
        checks++;
        if (busy !== 1'b0 || calc_start !== 1'b0 || rsp_valid !== 2'b00 ||
            rsp_error !== 1'b0 || rsp_timeout !== 1'b0 ||
            calc_op_type !== 4'd0 || calc_scalar !== 4'd0 ||
            calc_sel !== 1'b0 || ops_done !== 8'd0 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b%b%b%b%h%h%b%h%h exp=zeros",
                     busy, calc_start, rsp_valid, rsp_error, rsp_timeout,
                     calc_op_type, calc_scalar, calc_sel, ops_done, err_cnt);
        end
        req_valid = 2'b00;
        rst = 1'b0;
        m_rr  = 1'b0;
        m_ops = 8'd0;
        m_err = 8'd0;
        tick();
    endtask

    task automatic test_basic();
        run_op(2'b01, 4'b0010, 4'b0001, 4'h5, 4'h9, 3, 1'b0, 0);
        run_op(2'b10, 4'b0100, 4'b1000, 4'h1, 4'hc, 4, 1'b1, 0);
    endtask

    task automatic test_round_robin();
        logic [3:0] ops[4];
        ops[0] = 4'b0001;
        ops[1] = 4'b0010;
        ops[2] = 4'b0100;
        ops[3] = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            run_op(2'b11, ops[i], ops[3 - i], 4'(i), 4'(i + 8), 3, 1'b0, 0);
        end
        run_op(2'b01, 4'b0010, 4'b0010, 4'h3, 4'h4, 3, 1'b0, 0);
        run_op(2'b01, 4'b0100, 4'b0010, 4'h6, 4'h7, 3, 1'b0, 0);
    endtask

    task automatic test_illegal();
        run_op(2'b01, 4'b0011, 4'b0001, 4'h2, 4'h2, -1, 1'b0, 0);
        run_op(2'b10, 4'b0001, 4'b0000, 4'h2, 4'ha, -1, 1'b0, 0);
    endtask

    task automatic test_timeout();
        run_op(2'b01, 4'b1000, 4'b0001, 4'h7, 4'h0, -1, 1'b0, 0);
        run_op(2'b01, 4'b1000, 4'b0001, 4'h7, 4'h0, TMO + 2, 1'b1, 0);
        run_op(2'b10, 4'b1000, 4'b0001, 4'h7, 4'hb, TMO + 1, 1'b0, 0);
    endtask

    task automatic test_stale_done();
        run_op(2'b01, 4'b0100, 4'b0001, 4'hd, 4'h0, 0, 1'b0, 0);
    endtask

    task automatic test_stall();
        run_op(2'b10, 4'b0010, 4'b0001, 4'h0, 4'he, 3, 1'b1, 10);
    endtask

    task automatic test_reset_mid_wait();
        req_valid = 2'b01;
        req_op_0  = 4'b0010;
        calc_done = 1'b0;
        rsp_ready = 2'b11;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midwait_busy got=%b exp=1", busy);
        end
        rst = 1'b1;
        req_valid = 2'b11;
        tick();
        checks++;
        if (req_ready !== 2'b00 || busy !== 1'b0 || rsp_valid !== 2'b00 ||
            calc_start !== 1'b0 || calc_op_type !== 4'd0 ||
            ops_done !== 8'd0 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL midwait_reset got=%b%b%b%b%h%h%h exp=zeros",
                     req_ready, busy, rsp_valid, calc_start, calc_op_type,
                     ops_done, err_cnt);
        end
        rst = 1'b0;
        req_valid = 2'b00;
        calc_done = 1'b1;
        m_rr  = 1'b0;
        m_ops = 8'd0;
        m_err = 8'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midwait_idle i=%0d got=%b/%b exp=00/0",
                         i, rsp_valid, busy);
            end
        end
        calc_done = 1'b0;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 256; i++) begin
            run_op(2'b01, 4'b0001, 4'b0001, 4'(i), 4'h0, 3, 1'b0, 0);
        end
        checks++;
        if (ops_done !== 8'd0) begin
            failures++;
            $display("FAIL ops_wrap got=%0d exp=0", ops_done);
        end
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 2'b00;
        req_op_0     = 4'd0;
        req_op_1     = 4'd0;
        req_scalar_0 = 4'd0;
        req_scalar_1 = 4'd0;
        calc_done    = 1'b0;
        calc_error   = 1'b0;
        rsp_ready    = 2'b00;
        test_reset();
        test_basic();
        test_round_robin();
        test_illegal();
        test_timeout();
        test_stale_done();
        test_stall();
        test_reset_mid_wait();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_op_scheduler.md
MATRIX_OP_SCHEDULER -- requirements
Module: matrix_op_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max WAIT cycles before abort (1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  2  per-requester request (bit0 = requester 0, bit1 = requester 1).
REQ-005 SHALL have ports req_op_0 and req_op_1  input  4 each  op_type: 0001 transpose, 0010 add, 0100 scalar, 1000 multiply.
REQ-006 SHALL have ports req_scalar_0 and req_scalar_1  input  4 each  scalar operand.
REQ-007 SHALL have port req_ready  output  2  accept strobe; request taken when valid&ready.
REQ-008 SHALL have port calc_start  output  1  one-cycle launch pulse to the calc unit.
REQ-009 SHALL have ports calc_op_type  output  4  and calc_scalar  output  4  latched op and scalar.
REQ-010 SHALL have port calc_sel  output  1  granted requester ID (matrix-source mux select).
REQ-011 SHALL have ports calc_done  input  1  and calc_error  input  1  level status from the calc unit.
REQ-012 SHALL have port rsp_valid  output  2  response to the owning requester.
REQ-013 SHALL have port rsp_ready  input  2  response consume.
REQ-014 SHALL have ports rsp_error  output  1  and rsp_timeout  output  1  response status.
REQ-015 SHALL have ports busy  output  1  (state != IDLE), ops_done  output  8  and err_cnt  output  8.

Function
REQ-016 SHALL implement FSM states IDLE, LAUNCH, WAIT, RESP.
REQ-017 IDLE: if any req_valid, SHALL grant exactly one requester, assert its req_ready bit combinationally in that cycle, and latch op, scalar and ID.
REQ-018 Arbitration SHALL be round-robin: rr_ptr names the preferred requester; after each RESP handshake rr_ptr = ~granted ID; a lone requester always wins.
REQ-019 req_ready SHALL be 0 in every state other than IDLE.
REQ-020 Latched op not one-hot among the four legal codes: SHALL go IDLE->RESP with rsp_error=1, rsp_timeout=0, and no calc_start.
REQ-021 Legal op: SHALL go IDLE->LAUNCH; in LAUNCH calc_start=1 for exactly one cycle, then WAIT.
REQ-022 calc_op_type, calc_scalar and calc_sel SHALL hold their latched values stable from LAUNCH through RESP.
REQ-023 WAIT: an 8-bit counter SHALL clear on entry and increment each cycle; calc_done SHALL be ignored in the first WAIT cycle (stale-done guard).
REQ-024 WAIT with calc_done=1 (second cycle on): SHALL latch rsp_error=calc_error, rsp_timeout=0, and go to RESP.
REQ-025 WAIT with counter==TIMEOUT and calc_done=0: SHALL go to RESP with rsp_error=1, rsp_timeout=1; if done and timeout occur in the same cycle, done wins.
REQ-026 Minimum latency: accept at cycle T, calc_start at T+1, earliest done sample at T+3, rsp_valid at T+4.
REQ-027 RESP: rsp_valid[ID] SHALL be 1 (other bit 0) and held, with status stable, until rsp_ready[ID]=1; then go to IDLE, so no new grant is possible in that same cycle.
REQ-028 On each RESP handshake, ops_done SHALL increment, wrapping 255->0, and err_cnt SHALL increment when rsp_error=1, saturating at 255.
REQ-029 req_valid changes outside IDLE SHALL be ignored; rsp_ready bits for the non-owning requester SHALL be ignored.

Reset
REQ-030 With rst=1 at a clock edge, the block SHALL enter IDLE, clear rr_ptr, the WAIT counter, ops_done and err_cnt, and drive calc_start, rsp_valid, rsp_error, rsp_timeout, calc_op_type, calc_scalar, calc_sel and busy to 0.
REQ-031 Reset in any state, including mid-WAIT, SHALL abort the operation with no response issued; req_ready SHALL be 0 while rst=1.

Verification
REQ-032 Scenario: req_valid=01, op 0010, calc_done=1 on the 2nd WAIT cycle, error 0, rsp_ready=1 -> calc_start single pulse at T+1, rsp_valid=01 at T+4, rsp_error=0, ops_done=1.
REQ-033 Scenario: req_valid=11 held for 4 ops -> grants alternate 0,1,0,1 and calc_sel follows the grant.
REQ-034 Scenario: op 0011 -> no calc_start, rsp_valid next cycle, rsp_error=1, err_cnt=1.
REQ-035 Scenario: TIMEOUT=4, calc_done held 0 -> RESP after counter reaches 4, rsp_error=1, rsp_timeout=1.
REQ-036 Scenario: rst pulsed mid-WAIT -> next cycle IDLE, all outputs 0, no rsp_valid; calc_done=1 already high before start -> ignored in 1st WAIT cycle.
REQ-037 Scenario: rsp_ready held 0 for 10 cycles -> rsp_valid and status stable, req_ready=0 throughout; 256 completed ops -> ops_done wraps to 0.
